// File: rtl/decode_queue.sv
// In-order decode queue between instruction fetch and the RS/LSB/ROB dispatch ports.
// The head is decoded combinationally and dispatched only when its own target unit can accept it.
module decode_queue #(
  parameter int QDEPTH = 4,
  parameter int ROB_W  = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_addr,
  input  logic [31:0]      if_ins,
  input  logic             if_pred_jmp,
  input  logic [31:0]      if_pred_another,
  output logic [4:0]       get_id_1,
  input  logic [31:0]      get_val_1,
  input  logic             get_has_dep_1,
  input  logic [ROB_W-1:0] get_dep_1,
  output logic [4:0]       get_id_2,
  input  logic [31:0]      get_val_2,
  input  logic             get_has_dep_2,
  input  logic [ROB_W-1:0] get_dep_2,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_id,
  input  logic [31:0]      cdb_val,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic             rob_full,
  input  logic             rob_clear,
  input  logic [ROB_W-1:0] rob_free_id,
  output logic             d_rs,
  output logic             d_lsb,
  output logic [31:0]      d_pc,
  output logic [10:0]      d_op,
  output logic [31:0]      d_imm,
  output logic             d_iQi,
  output logic [ROB_W-1:0] d_Qi,
  output logic [31:0]      d_Vi,
  output logic             d_iQj,
  output logic [ROB_W-1:0] d_Qj,
  output logic [31:0]      d_Vj,
  output logic [ROB_W-1:0] d_Qdest,
  output logic             r_is_ins,
  output logic [31:0]      r_ins_pc,
  output logic             r_done,
  output logic [31:0]      r_result,
  output logic [4:0]       r_rd,
  output logic             r_pred_jmp,
  output logic [31:0]      r_another,
  output logic [1:0]       r_type
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] RTYPE = 2'd0;
  localparam logic [1:0] STYPE = 2'd1;
  localparam logic [1:0] BTYPE = 2'd2;
  localparam logic [1:0] JTYPE = 2'd3;

  logic [31:0]   q_pc      [QDEPTH];
  logic [31:0]   q_ins     [QDEPTH];
  logic          q_pred    [QDEPTH];
  logic [31:0]   q_another [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [31:0] h_pc, h_ins, h_imm, h_result;
  logic [6:0]  opc;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence, is_sys;
  logic is_illegal, needs_rs, needs_lsb, h_done;
  logic [4:0]  h_rd;
  logic [1:0]  h_type;
  logic fwd_1, fwd_2, dispatch, enq;

  assign if_ready = (count != CW'(QDEPTH));

  always_comb begin
    h_pc     = q_pc[head];
    h_ins    = q_ins[head];
    opc      = h_ins[6:0];
    is_lui   = (opc == OP_LUI);
    is_auipc = (opc == OP_AUIPC);
    is_jal   = (opc == OP_JAL);
    is_jalr  = (opc == OP_JALR);
    is_br    = (opc == OP_BR);
    is_ld    = (opc == OP_LD);
    is_st    = (opc == OP_ST);
    is_opi   = (opc == OP_OPI);
    is_op    = (opc == OP_OP);
    is_fence = (opc == OP_FENCE);
    is_sys   = (opc == OP_SYS);
    is_illegal = !(is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st |
                   is_opi | is_op | is_fence | is_sys);
    needs_rs  = is_jalr | is_br | is_opi | is_op;
    needs_lsb = is_ld | is_st;

    get_id_1 = (is_lui | is_auipc | is_jal) ? 5'd0 : h_ins[19:15];
    get_id_2 = (is_jalr | is_opi | is_ld | is_lui | is_auipc | is_jal) ? 5'd0 : h_ins[24:20];

    h_imm = 32'd0;
    if (is_opi | is_ld | is_jalr) h_imm = {{20{h_ins[31]}}, h_ins[31:20]};
    else if (is_st)               h_imm = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
    else if (is_br)               h_imm = {{19{h_ins[31]}}, h_ins[31], h_ins[7], h_ins[30:25],
                                           h_ins[11:8], 1'b0};
    else if (is_lui | is_auipc)   h_imm = {h_ins[31:12], 12'd0};

    h_done   = is_lui | is_auipc | is_jal | is_jalr | is_fence | is_sys | is_illegal;
    h_result = 32'd0;
    if (is_lui)                h_result = h_imm;
    else if (is_auipc)         h_result = h_pc + h_imm;
    else if (is_jal | is_jalr) h_result = h_pc + 32'd4;

    h_rd = (is_st | is_br | is_fence | is_sys | is_illegal) ? 5'd0 : h_ins[11:7];
    if (is_st)                 h_type = STYPE;
    else if (is_br)            h_type = BTYPE;
    else if (is_jal | is_jalr) h_type = JTYPE;
    else                       h_type = RTYPE;

    // A pending operand whose producer broadcasts this cycle is captured from the CDB.
    fwd_1 = get_has_dep_1 && cdb_valid && (cdb_id == get_dep_1);
    fwd_2 = get_has_dep_2 && cdb_valid && (cdb_id == get_dep_2);

    dispatch = (count != '0) && rdy_in && !rob_clear && !rob_full &&
               (!needs_rs || !rs_full) && (!needs_lsb || !lsb_full);
    enq      = if_valid && if_ready && rdy_in && !rob_clear;
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      q_pc[tail]      <= if_addr;
      q_ins[tail]     <= if_ins;
      q_pred[tail]    <= if_pred_jmp;
      q_another[tail] <= if_pred_another;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0; tail <= '0; count <= '0;
      d_rs <= 1'b0; d_lsb <= 1'b0; r_is_ins <= 1'b0;
      d_pc <= '0; d_op <= '0; d_imm <= '0;
      d_iQi <= 1'b0; d_Qi <= '0; d_Vi <= '0;
      d_iQj <= 1'b0; d_Qj <= '0; d_Vj <= '0; d_Qdest <= '0;
      r_ins_pc <= '0; r_done <= 1'b0; r_result <= '0; r_rd <= '0;
      r_pred_jmp <= 1'b0; r_another <= '0; r_type <= '0;
    end else if (rob_clear) begin
      head <= '0; tail <= '0; count <= '0;
      d_rs <= 1'b0; d_lsb <= 1'b0; r_is_ins <= 1'b0;
    end else if (rdy_in) begin
      if (enq)      tail <= tail + PW'(1);
      if (dispatch) head <= head + PW'(1);
      count    <= count + CW'(enq) - CW'(dispatch);
      d_rs     <= dispatch && needs_rs;
      d_lsb    <= dispatch && needs_lsb;
      r_is_ins <= dispatch;
      if (dispatch) begin
        d_pc       <= h_pc;
        d_op       <= {h_ins[30], h_ins[14:12], h_ins[6:0]};
        d_imm      <= h_imm;
        d_iQi      <= !get_has_dep_1 || fwd_1;
        d_Qi       <= get_dep_1;
        d_Vi       <= fwd_1 ? cdb_val : get_val_1;
        d_iQj      <= !get_has_dep_2 || fwd_2;
        d_Qj       <= get_dep_2;
        d_Vj       <= fwd_2 ? cdb_val : get_val_2;
        d_Qdest    <= rob_free_id;
        r_ins_pc   <= h_pc;
        r_done     <= h_done;
        r_result   <= h_result;
        r_rd       <= h_rd;
        r_pred_jmp <= q_pred[head];
        r_another  <= q_another[head];
        r_type     <= h_type;
      end
    end
  end
endmodule
